// File: rtl/orientation_pkg.sv
// Shared constants and the packed-word type for the orientation FIFO write-side packer.
package orientation_pkg;
  localparam int SW     = 16;
  localparam int LANES  = 8;
  localparam int WW     = LANES * SW;
  localparam int LIDX_W = $clog2(LANES);
  localparam logic [SW-1:0] PAD_DEFAULT = 16'h0000;

  typedef logic [LANES-1:0][SW-1:0] word_t;
endpackage

// File: rtl/orientation_lane_packer.sv
// Lane register and fill count: accepted samples land in lane[count]; a completing sample
// (lane 7 or last) pads the lanes above it and returns count to 0. word_next is the post-edge word.
module orientation_lane_packer
  import orientation_pkg::*;
#(
  parameter logic [SW-1:0] PAD = PAD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic [SW-1:0]     data,
  input  logic              last,
  output word_t             word_next,
  output word_t             word_held,
  output logic              done,
  output logic [LIDX_W-1:0] count
);
  word_t lanes;

  assign done      = accept && (last || count == LIDX_W'(LANES - 1));
  assign word_held = lanes;

  always_comb begin
    word_next = lanes;
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (LIDX_W'(i) == count) begin
          word_next[i] = data;
        end else if (done && LIDX_W'(i) > count) begin
          word_next[i] = PAD;
        end
      end
    end
  end

  // While a completed word waits for the output register, accept stays low so lanes hold it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lanes <= '0;
      count <= '0;
    end else if (accept) begin
      lanes <= word_next;
      count <= done ? '0 : count + LIDX_W'(1);
    end
  end
endmodule

// File: rtl/orientation_fifo_packer.sv
// Packs 16-bit orientation samples into 128-bit FIFO words (lane 0 = first sample), one-word skid
// behind the output register; owrreq only while FIFO not full. ORIENT_PACK_WORDCNT_EN adds counters.
module orientation_fifo_packer
  import orientation_pkg::*;
#(
  parameter logic [SW-1:0] PAD = PAD_DEFAULT
) (
  input  logic          iclk,
  input  logic          ireset,
  input  logic [SW-1:0] idata,
  input  logic          ivalid,
  input  logic          ilast,
  output logic          oready,
  input  logic          iwrfull,
  output logic          owrreq,
  output logic [WW-1:0] owdata,
  output logic          obusy
`ifdef ORIENT_PACK_WORDCNT_EN
  ,
  output logic [15:0]   owordcnt,
  output logic [15:0]   okpcnt
`endif
);
  logic              accept;
  logic              done;
  logic              pack_full;
  logic              out_valid;
  logic              out_free;
  logic [LIDX_W-1:0] count;
  word_t             word_next;
  word_t             word_held;
  word_t             out_word;

  orientation_lane_packer #(.PAD(PAD)) u_lanes (
    .clk       (iclk),
    .reset     (ireset),
    .accept    (accept),
    .data      (idata),
    .last      (ilast),
    .word_next (word_next),
    .word_held (word_held),
    .done      (done),
    .count     (count)
  );

  assign oready   = !pack_full;
  assign accept   = ivalid && oready;
  // Gated by reset so a buffered word is never written on the discarding cycle.
  assign owrreq   = out_valid && !iwrfull && !ireset;
  assign out_free = !out_valid || owrreq;
  assign owdata   = out_word;
  assign obusy    = (count != '0) || pack_full || out_valid;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      pack_full <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (done && out_free) begin
      out_word  <= word_next;
      out_valid <= 1'b1;
    end else if (done) begin
      pack_full <= 1'b1;
    end else if (pack_full && out_free) begin
      out_word  <= word_held;
      out_valid <= 1'b1;
      pack_full <= 1'b0;
    end else if (owrreq) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ORIENT_PACK_WORDCNT_EN
  always_ff @(posedge iclk) begin
    if (ireset) begin
      owordcnt <= '0;
      okpcnt   <= '0;
    end else begin
      if (owrreq) owordcnt <= owordcnt + 16'd1;
      if (accept && ilast) okpcnt <= okpcnt + 16'd1;
    end
  end
`endif
endmodule

// File: doc/orientation_fifo_packer.md
Name: orientation_fifo_packer

Overview:
- Write-side feeder for the 128-bit-in / 16-bit-out orientation dual-clock FIFO.
- Packs a stream of 16-bit orientation samples into 128-bit words, 8 lanes per word.
- Drives the FIFO write request only while the FIFO reports not-full.
- Sits in the 50 MHz write clock domain, between the orientation histogram datapath and the FIFO write port.

Parameters:
- LANES, 8, samples per packed word; fixed to 8 for the 128/16 ratio.
- SW, 16, sample width in bits.
- PAD, 16'h0000, value written into unused lanes of a partial word flushed by ilast.

Ports:
- iclk  in  1  write-domain clock (50 MHz).
- ireset  in  1  synchronous active-high reset, sampled on rising iclk.
- idata  in  16  input sample.
- ivalid  in  1  idata valid.
- ilast  in  1  last sample of a keypoint, qualified by ivalid; forces a flush.
- oready  out  1  block can accept a sample this cycle.
- iwrfull  in  1  FIFO write-side full flag.
- owrreq  out  1  FIFO write request.
- owdata  out  128  FIFO write data.
- obusy  out  1  pack or output register holds data.

Behaviour:
- Reset values:
  - oready=1, owrreq=0, owdata=0, obusy=0.
  - Lane count=0, pack_full=0, out_valid=0.
- Handshake: a sample is accepted on any edge where ivalid && oready. oready = !pack_full.
- Lane order:
  - First sample of a word goes to bits [15:0], the k-th to [16k+15:16k].
  - The FIFO's 16-bit read side emits lanes LSB-first, so order is preserved end to end.
- Packing:
  - Each accepted sample is written to lane[count], then count increments.
  - A word completes when count==7 or ilast is set.
  - On completion, lanes above the current one are filled with PAD, and count returns to 0.
- Transfer of a completed word:
  - If out is free (out_valid==0, or owrreq==1 this cycle), the word loads into owdata on the completing edge and out_valid=1.
  - Otherwise the word stays in the pack register, pack_full=1 and oready=0.
  - The held word moves to out on the first edge where out is free; pack_full then clears.
- Write side:
  - owrreq = out_valid && !iwrfull (combinational).
  - out_valid clears on an owrreq edge unless a new word loads on that same edge.
- Latency: 8th (or ilast) sample accepted at edge N gives owrreq=1 in cycle N+1 when iwrfull=0.
- Throughput: sustained 1 sample/cycle with iwrfull low.
- Boundaries:
  - ilast on lane 7: no padding, normal word.
  - ilast on lane 0: a word with lane0=data and 7 PAD lanes.
  - iwrfull held high: at most 2 words are buffered, then oready=0. No word is ever dropped or duplicated.
  - ivalid while oready=0: sample ignored; the source must hold it.
  - ireset mid-word: partial and buffered words are discarded, with no write on the reset cycle or after it.
- obusy = (count!=0) || pack_full || out_valid.

Optional Feature:
- Macro ORIENT_PACK_WORDCNT_EN.
- When defined:
  - Extra output owordcnt [15:0]: increments on every owrreq edge, wraps at 16'hFFFF→0, cleared by ireset.
  - Extra output okpcnt [15:0]: counts accepted ilast samples, same wrap and reset rules.
- When undefined: neither port exists and no counter logic is built.

Decomposition:
- Package orientation_pkg holds: SW, LANES, word width (LANES*SW), PAD default, lane-index width ($clog2(LANES)).
- One sub-module, orientation_lane_packer: lane register, count, PAD fill and completion flag.
- The top level holds the pack_full/out_valid hand-off and the FIFO write logic.

Test Plan:
- Reset, then 16 samples 0x0001..0x0010 back-to-back with iwrfull=0 → two owrreq pulses. owdata = {0x0008..0x0001} then {0x0010..0x0009}; first pulse one cycle after the 8th accept; oready stays 1.
- 3 samples 0xAAAA,0xBBBB,0xCCCC, ilast on the third → one word with lanes0-2 = AAAA,BBBB,CCCC and lanes3-7 = 0x0000.
- iwrfull=1 and 24 samples offered → exactly 2 words buffered and oready=0 after the 16th accept. Drop iwrfull → 3 correct words in order, no duplicates.
- iwrfull toggles every cycle during continuous input → owrreq never set while iwrfull=1; output sequence matches the input exactly.
- ireset asserted after 5 samples → no write; the next 8 samples form a clean word starting at lane 0.
- With ORIENT_PACK_WORDCNT_EN: 3 keypoints of 8, 3 and 9 samples → owordcnt=4 and okpcnt=3.
